// File: rtl/cnt_seq_monitor.sv
// Sequence checker for the 2-bit 00->01->10->00 counter.
// Counts completed wraps and illegal steps; latches FAULT at the error limit.
module cnt_seq_monitor #(
    parameter int CYC_W     = 8,
    parameter int ERR_W     = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       cnt_in,
    output logic             locked,
    output logic             fault,
    output logic             wrap,
    output logic             err,
    output logic             unused_seen,
    output logic [CYC_W-1:0] cycles,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         prev_q, prev_d;
    logic               locked_q, locked_d;
    logic               fault_q, fault_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               unused_q, unused_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0]   err_inc;
    logic [CYC_W-1:0]   cyc_inc;

    function automatic logic [1:0] exp_next(input logic [1:0] p);
        unique case (p)
            2'b00:   exp_next = 2'b01;
            2'b01:   exp_next = 2'b10;
            default: exp_next = 2'b00;
        endcase
    endfunction

    assign err_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
    assign cyc_inc = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        unused_d  = unused_q;
        cycles_d  = cycles_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            state_d   = IDLE;
            prev_d    = 2'b00;
            unused_d  = 1'b0;
            cycles_d  = '0;
            err_cnt_d = '0;
        end else if (en && state_q != FAULT) begin
            if (cnt_in == 2'b11) unused_d = 1'b1;
            prev_d = cnt_in;
            unique case (state_q)
                IDLE: state_d = LOCK;
                LOCK: begin
                    if (cnt_in == exp_next(prev_q)) begin
                        // 11->00 is legal recovery, only 10->00 closes a cycle
                        if (prev_q == 2'b10) begin
                            wrap_d   = 1'b1;
                            cycles_d = cyc_inc;
                        end
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = err_inc;
                        if (err_inc >= ERR_W'(ERR_LIMIT)) state_d = FAULT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        locked_d = (state_d == LOCK);
        fault_d  = (state_d == FAULT);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            prev_q    <= 2'b00;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            unused_q  <= 1'b0;
            cycles_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            locked_q  <= locked_d;
            fault_q   <= fault_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
            unused_q  <= unused_d;
            cycles_q  <= cycles_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked      = locked_q;
    assign fault       = fault_q;
    assign wrap        = wrap_q;
    assign err         = err_q;
    assign unused_seen = unused_q;
    assign cycles      = cycles_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Scoreboard bench for cnt_seq_monitor against a behavioural sequence model.
// Stimulus pushes expected outputs; a monitor pops and compares after each edge.
module tb_cnt_seq_monitor;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] cnt_in = 2'b00;
    logic       locked, fault, wrap, err, unused_seen;
    logic [7:0] cycles;
    logic [3:0] err_cnt;

    cnt_seq_monitor #(.CYC_W(8), .ERR_W(4), .ERR_LIMIT(3)) dut (
        .Clk(Clk), .Rst(Rst), .en(en), .clr(clr), .cnt_in(cnt_in),
        .locked(locked), .fault(fault), .wrap(wrap), .err(err),
        .unused_seen(unused_seen), .cycles(cycles), .err_cnt(err_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       locked;
        logic       fault;
        logic       wrap;
        logic       err;
        logic       unused;
        logic [7:0] cycles;
        logic [3:0] errc;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, want;
    int   vectors = 0;
    int   miscompares = 0;

    // Model: mode 0=idle 1=lock 2=fault; counts kept as plain integers
    int         m_mode = 0;
    int         m_cyc = 0;
    int         m_errc = 0;
    bit         m_unused = 0;
    logic [1:0] m_prev = 2'b00;
    logic [1:0] succ [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
    logic [1:0] legal_seq [3] = '{2'd1, 2'd2, 2'd0};

    function automatic obs_t sample_dut();
        obs_t o;
        o = '{locked, fault, wrap, err, unused_seen, cycles, err_cnt};
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cyc = 0; m_errc = 0; m_unused = 0; m_prev = 2'b00;
    endtask

    task automatic step(input bit e, input bit c, input logic [1:0] v);
        bit w, er;
        obs_t o;
        @(negedge Clk);
        en = e; clr = c; cnt_in = v;
        w = 0; er = 0;
        if (c) begin
            m_mode = 0; m_cyc = 0; m_errc = 0; m_unused = 0; m_prev = 2'b00;
        end else if (e && m_mode != 2) begin
            if (v == 2'b11) m_unused = 1;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (v == succ[m_prev]) begin
                if (m_prev == 2'b10) begin
                    w = 1;
                    m_cyc = (m_cyc < 255) ? m_cyc + 1 : 255;
                end
            end else begin
                er = 1;
                m_errc = (m_errc < 15) ? m_errc + 1 : 15;
                if (m_errc >= 3) m_mode = 2;
            end
            m_prev = v;
        end
        o.locked = (m_mode == 1);
        o.fault  = (m_mode == 2);
        o.wrap   = w;
        o.err    = er;
        o.unused = m_unused;
        o.cycles = 8'(m_cyc);
        o.errc   = 4'(m_errc);
        exp_q.push_back(o);
    endtask

    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = sample_dut();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got=%b want=%b (lk,ft,wr,er,un,cyc,ec)",
                         $time, got, want);
            end
        end
    end

    task automatic check_zero(input string name);
        obs_t z;
        z = '0;
        got = sample_dut();
        vectors++;
        if (got !== z) begin
            miscompares++;
            $display("FAIL %s got=%b want=%b", name, got, z);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge Clk); #2;
            n++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            vectors++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [1:0] v;
        repeat (3) @(negedge Clk);
        check_zero("reset_state");
        Rst = 1'b1;
        model_reset();

        // Reset and lock
        step(1, 0, 2'b00);
        step(1, 0, 2'b01);
        step(1, 0, 2'b10);
        step(1, 0, 2'b00);

        // Long legal run saturates cycles
        step(1, 1, 2'b00);
        step(1, 0, 2'b00);
        for (int i = 0; i < 900; i++) step(1, 0, legal_seq[i % 3]);

        // Unused-state recovery
        step(1, 1, 2'b00);
        step(1, 0, 2'b01);
        step(1, 0, 2'b11);
        step(1, 0, 2'b00);
        step(1, 0, 2'b01);

        // Fault entry, then frozen behaviour
        step(1, 1, 2'b00);
        step(1, 0, 2'b00);
        step(1, 0, 2'b10);
        step(1, 0, 2'b01);
        step(1, 0, 2'b01);
        step(1, 0, 2'b10);
        step(1, 0, 2'b00);
        step(1, 0, 2'b11);
        step(1, 0, 2'b01);

        // Enable gating and clear
        step(1, 1, 2'b00);
        step(1, 0, 2'b00);
        step(1, 0, 2'b01);
        for (int i = 0; i < 12; i++) step(0, 0, 2'($urandom));
        step(1, 1, 2'b11);
        step(1, 0, 2'b10);
        step(1, 0, 2'b00);

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 85) v = succ[m_prev];
            else v = 2'($urandom);
            step(($urandom_range(9) < 8), ($urandom_range(99) < 3), v);
        end

        // Five wraps, then async reset between edges
        step(1, 1, 2'b00);
        step(1, 0, 2'b00);
        for (int i = 0; i < 15; i++) step(1, 0, legal_seq[i % 3]);
        drain();
        @(negedge Clk);
        en = 1'b1; cnt_in = 2'b01;
        #2;
        Rst = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        step(1, 0, 2'b10);
        step(1, 0, 2'b00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cnt_seq_monitor.md
Name: cnt_seq_monitor

Overview:
- Downstream consumer of the 2-bit T-flip-flop sequence counter (legal sequence 00->01->10->00; 11 unused, self-corrects to 00).
- Samples the counter output each enabled clock and checks every transition against that sequence.
- Counts completed count cycles, counts sequence errors, and latches a fault state once errors reach a limit.
- Used as the self-check stage behind the counter in chapter exercises and benches.

Parameters:
- CYC_W, 8, width of completed-cycle counter (saturating).
- ERR_W, 4, width of error counter (saturating).
- ERR_LIMIT, 3, error count at which FSM enters FAULT (1..2^ERR_W-1).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous active-low reset.
- en  input  1  sample enable; cnt_in checked only when en=1.
- clr  input  1  synchronous clear of counters/flags; returns FSM to IDLE.
- cnt_in  input  2  counter value under observation.
- locked  output  1  FSM in LOCK.
- fault  output  1  FSM in FAULT.
- wrap  output  1  one-cycle pulse on legal 10->00 transition.
- err  output  1  one-cycle pulse on illegal transition.
- unused_seen  output  1  sticky; set when cnt_in==11 sampled.
- cycles  output  CYC_W  completed-cycle count, saturating.
- err_cnt  output  ERR_W  error count, saturating.

Behaviour:
- Reset (Rst=0, async): state=IDLE, prev=00, all outputs 0. Release takes effect at the next rising Clk edge.
- All outputs are registered; each response appears the cycle after the sampling edge (latency 1).
- Expected-next function exp(p): 00->01, 01->10, 10->00, 11->00.
- FSM states: IDLE, LOCK, FAULT.
- IDLE:
  - en=1: store prev=cnt_in, go LOCK.
  - No error check, no wrap pulse.
  - cnt_in==11 still sets unused_seen.
- LOCK, en=1:
  - cnt_in==exp(prev): legal. If prev==10 and cnt_in==00, pulse wrap and increment cycles (hold at all-ones). A 11->00 recovery is legal but not a wrap.
  - Otherwise: pulse err and increment err_cnt (hold at all-ones). If the incremented value >= ERR_LIMIT, go FAULT on the same edge.
  - In both cases prev=cnt_in; re-lock to the observed value, no resync stall.
- LOCK, en=0: hold everything. wrap and err are 0.
- FAULT:
  - fault=1, locked=0.
  - No further checking: cycles, err_cnt and prev frozen; wrap and err stay 0.
  - Left only by clr or Rst.
- clr=1 (synchronous, priority over en):
  - state=IDLE; cycles, err_cnt, unused_seen and pulses cleared.
  - Any sample at that edge is ignored.
- unused_seen: set in any state except FAULT when en=1 and cnt_in==11; cleared only by clr/Rst.
- Simultaneous events at one edge:
  - Transition 11->00 is legal and sets neither wrap nor err.
  - Error reaching ERR_LIMIT asserts err and enters FAULT at the same edge, so err and fault are both seen the following cycle.
- Saturation: cycles and err_cnt never wrap to 0.
- Rst asserted mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Reset and lock:
  - Stimulus: Rst=0, then release; en=1; cnt_in 00,01,10,00.
  - Response: locked=1 one cycle after first sample; wrap pulses once; cycles=1; err_cnt=0.
- Long legal run:
  - Stimulus: 300 legal cycles with CYC_W=8.
  - Response: cycles saturates at 255; err never asserted.
- Unused-state recovery:
  - Stimulus: sequence 01,11,00,01.
  - Response: 01->11 is an error (err_cnt=1); 11->00 legal with no wrap; unused_seen=1.
- Fault entry:
  - Stimulus: three illegal transitions (00->10, 10->01, 01->01), ERR_LIMIT=3.
  - Response: err pulses ×3; fault=1 after the third; subsequent legal sequence leaves cycles/err_cnt unchanged.
- Enable gating and clear:
  - Stimulus: en=0 while cnt_in toggles arbitrarily, then clr=1 for one cycle while en=1.
  - Response: no counts change while en=0; after clr, state IDLE with all counters 0; next en sample re-locks.
- Async reset mid-run:
  - Stimulus: Rst=0 between clock edges during LOCK with cycles=5.
  - Response: outputs 0 immediately, before the next edge.
